// File: rtl/storage_pkg.sv
// Shared defaults and helpers for the storage unit: default widths,
// the stack-pointer width function and the stack operation encoding.
package storage_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int STACK_DEPTH_DEF = 16;

   // One extra bit so the pointer can express both 0 and STACK_DEPTH.
   function automatic int sp_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef enum logic [1:0] {
      OP_IDLE,
      OP_PUSH,
      OP_POP,
      OP_SWAP
   } stack_op_e;

endpackage : storage_pkg

// File: rtl/lifo_core.sv
// Stack array plus occupancy pointer. Push+pop on a non-empty stack replaces
// the top in place; push+pop on an empty stack degrades to a plain push.
module lifo_core
   import storage_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF,
   localparam int SP_W       = sp_width(STACK_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] top_o,
   output logic              pop_fire_o,
   output logic [SP_W-1:0]   sp_o
);

   localparam int            AW      = SP_W - 1;
   localparam logic [SP_W-1:0] DEPTH_V = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] LAST_V  = SP_W'(STACK_DEPTH - 1);

   logic [DATA_W-1:0] mem_q [STACK_DEPTH];
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [AW-1:0]     top_idx, wr_idx;
   stack_op_e         op;

   // Index arithmetic wraps in AW bits, so sp=0 and sp=DEPTH both map the top to DEPTH-1.
   assign top_idx = sp_q[AW-1:0] - AW'(1);

   // NOTE: every signal assigned in always_comb gets a default first, or a latch is inferred.
   always_comb begin
      op = OP_IDLE;
      if (push_i && pop_i) op = (sp_q == '0) ? OP_PUSH : OP_SWAP;
      else if (push_i)     op = OP_PUSH;
      else if (pop_i)      op = OP_POP;
   end

   always_comb begin
      sp_d   = sp_q;
      wr_idx = sp_q[AW-1:0];
      unique case (op)
         OP_PUSH: sp_d   = (sp_q == DEPTH_V) ? '0 : sp_q + SP_W'(1);
         OP_POP:  sp_d   = (sp_q == '0) ? LAST_V : sp_q - SP_W'(1);
         OP_SWAP: wr_idx = top_idx;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sp_q <= '0;
      else     sp_q <= sp_d;
   end

   // NOTE: storage arrays are deliberately not reset; only the pointer is.
   always_ff @(posedge clk) begin
      if (!rst && (op == OP_PUSH || op == OP_SWAP)) mem_q[wr_idx] <= data_i;
   end

   assign top_o      = mem_q[top_idx];
   assign pop_fire_o = (op == OP_POP) || (op == OP_SWAP);
   assign sp_o       = sp_q;

endmodule : lifo_core

// File: rtl/storage_unit.sv
// Storage unit: inline data RAM with registered read plus a LIFO call stack.
// Define STORAGE_UNIT_STACK_GUARD_EN to block overflow/underflow and expose a sticky fault flag.
module storage_unit
   import storage_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
`ifdef STORAGE_UNIT_STACK_GUARD_EN
   output logic                                fault,
`endif
   input  logic                                store,
   input  logic                                load,
   input  logic                                push,
   input  logic                                pop,
   input  logic                                call,
   input  logic                                ret,
   input  logic [DATA_W-1:0]                   ram_addr,
   input  logic [DATA_W-1:0]                   data_in,
   input  logic [DATA_W-1:0]                   return_counter,
   output logic [DATA_W-1:0]                   data_out,
   output logic                                out_valid,
   output logic                                pc_load,
   output logic [DATA_W-1:0]                   pc_out,
   output logic [sp_width(STACK_DEPTH)-1:0]    sp,
   output logic                                full,
   output logic                                empty
);

   localparam int SP_W = sp_width(STACK_DEPTH);

   logic [DATA_W-1:0] ram_q [2**DATA_W];
   logic [DATA_W-1:0] push_src, stack_top;
   logic [SP_W-1:0]   sp_w;
   logic              push_g, pop_g, pop_fire, load_fire;

   logic [DATA_W-1:0] data_out_q, data_out_d, pc_out_q, pc_out_d;
   logic              out_valid_q, out_valid_d, pc_load_q, pc_load_d;

   assign push_src = call ? return_counter : data_in;
   assign full     = (sp_w == SP_W'(STACK_DEPTH));
   assign empty    = (sp_w == '0);

`ifdef STORAGE_UNIT_STACK_GUARD_EN
   logic fault_q, fault_d;

   // A lone push at full or lone pop at empty is dropped; paired push+pop stays legal.
   always_comb begin
      push_g  = push && !(full && !pop);
      pop_g   = pop && !(empty && !push);
      fault_d = fault_q || (push && !push_g) || (pop && !pop_g);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end

   assign fault = fault_q;
`else
   assign push_g = push;
   assign pop_g  = pop;
`endif

   lifo_core #(
      .DATA_W     (DATA_W),
      .STACK_DEPTH(STACK_DEPTH)
   ) u_lifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push_g),
      .pop_i     (pop_g),
      .data_i    (push_src),
      .top_o     (stack_top),
      .pop_fire_o(pop_fire),
      .sp_o      (sp_w)
   );

   // Registered read samples the pre-write word, giving read-before-write on a shared address.
   always_ff @(posedge clk) begin
      if (!rst && store) ram_q[ram_addr] <= data_in;
   end

   // Any asserted pop owns data_out for the cycle, even when the pop itself is ineffective.
   always_comb begin
      load_fire   = load && !pop;
      out_valid_d = pop_fire || load_fire;
      data_out_d  = data_out_q;
      if (pop_fire)       data_out_d = stack_top;
      else if (load_fire) data_out_d = ram_q[ram_addr];
      pc_load_d   = pop_fire && ret;
      pc_out_d    = pc_load_d ? stack_top : pc_out_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         pc_load_q   <= 1'b0;
         pc_out_q    <= '0;
      end else begin
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         pc_load_q   <= pc_load_d;
         pc_out_q    <= pc_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign pc_load   = pc_load_q;
   assign pc_out    = pc_out_q;
   assign sp        = sp_w;

endmodule : storage_unit

// File: tb/tb_storage_unit.sv
// Scoreboard bench for storage_unit: stimulus queues expected read/pop results,
// a negedge monitor retires them on every out_valid pulse.
module tb_storage_unit;

   typedef struct {
      logic [7:0] data;
      logic       pcl;
      logic [7:0] pc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       store = 0, load = 0, push = 0, pop = 0, call = 0, ret = 0;
   logic [7:0] ram_addr = '0, data_in = '0, return_counter = '0;
   logic [7:0] data_out, pc_out;
   logic       out_valid, pc_load, full, empty;
   logic [4:0] sp;
`ifdef STORAGE_UNIT_STACK_GUARD_EN
   logic       fault;
`endif

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t exp_q[$];

   storage_unit #(.DATA_W(8), .STACK_DEPTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef STORAGE_UNIT_STACK_GUARD_EN
      .fault         (fault),
`endif
      .store         (store),
      .load          (load),
      .push          (push),
      .pop           (pop),
      .call          (call),
      .ret           (ret),
      .ram_addr      (ram_addr),
      .data_in       (data_in),
      .return_counter(return_counter),
      .data_out      (data_out),
      .out_valid     (out_valid),
      .pc_load       (pc_load),
      .pc_out        (pc_out),
      .sp            (sp),
      .full          (full),
      .empty         (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      {store, load, push, pop, call, ret} = '0;
   endtask

   task automatic expect_out(input logic [7:0] d, input logic pcl, input logic [7:0] pc);
      exp_t e;
      e.data = d;
      e.pcl  = pcl;
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("pc_load", 32'(pc_load), 32'(e.pcl));
            if (e.pcl) check("pc_out", 32'(pc_out), 32'(e.pc));
         end
      end else if (!rst && pc_load) begin
         check("pc_load_without_valid", 32'(pc_load), 32'd0);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // Reset state
      step(); step();
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_pc_load", 32'(pc_load), 32'h0);
      check("rst_pc_out", 32'(pc_out), 32'h0);
      check("rst_sp", 32'(sp), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_full", 32'(full), 32'h0);
`ifdef STORAGE_UNIT_STACK_GUARD_EN
      check("rst_fault", 32'(fault), 32'h0);
`endif
      rst = 1'b0;
      step();

      // Store then load
      store = 1; ram_addr = 8'h10; data_in = 8'h5A; step(); idle();
      load = 1; ram_addr = 8'h10; expect_out(8'h5A, 0, 8'h00); step(); idle();

      // Store+load same address returns old data, then new data
      store = 1; load = 1; ram_addr = 8'h10; data_in = 8'h77;
      expect_out(8'h5A, 0, 8'h00); step(); idle();
      load = 1; expect_out(8'h77, 0, 8'h00); step(); idle();
      step(); step();
      check("hold_data_out", 32'(data_out), 32'h77);
      check("hold_out_valid", 32'(out_valid), 32'h0);

      // Call push then return pop
      push = 1; call = 1; return_counter = 8'h24; data_in = 8'h99; step(); idle();
      check("call_sp", 32'(sp), 32'h1);
      pop = 1; ret = 1; expect_out(8'h24, 1, 8'h24); step(); idle();
      check("ret_sp", 32'(sp), 32'h0);
      check("ret_empty", 32'(empty), 32'h1);
      step();
      check("hold_pc_out", 32'(pc_out), 32'h24);

      // Push, swap, pop
      push = 1; data_in = 8'h01; step(); idle();
      push = 1; pop = 1; data_in = 8'h02; expect_out(8'h01, 0, 8'h00); step(); idle();
      check("swap_sp", 32'(sp), 32'h1);
      pop = 1; expect_out(8'h02, 0, 8'h00); step(); idle();
      check("swap_pop_sp", 32'(sp), 32'h0);

      // Push+pop on empty acts as push only
      push = 1; pop = 1; data_in = 8'h33; step(); idle();
      check("pp_empty_sp", 32'(sp), 32'h1);
      pop = 1; expect_out(8'h33, 0, 8'h00); step(); idle();

      // Load and pop together: pop wins
      push = 1; data_in = 8'h44; step(); idle();
      load = 1; pop = 1; ram_addr = 8'h10; expect_out(8'h44, 0, 8'h00); step(); idle();
      check("ldpop_sp", 32'(sp), 32'h0);

      // Fill to full, then one more push
      for (int i = 0; i < 16; i++) begin
         push = 1; data_in = 8'hA0 + 8'(i); step();
      end
      idle();
      check("fill_sp", 32'(sp), 32'd16);
      check("fill_full", 32'(full), 32'h1);
      push = 1; data_in = 8'hB0; step(); idle();
`ifdef STORAGE_UNIT_STACK_GUARD_EN
      check("ovf_sp", 32'(sp), 32'd16);
      check("ovf_fault", 32'(fault), 32'h1);
`else
      check("ovf_sp", 32'(sp), 32'd0);
      check("ovf_empty", 32'(empty), 32'h1);
`endif

      // Reset asserted mid-way through a load cycle
      load = 1; ram_addr = 8'h10;
      #3 rst = 1'b1;
      #1;
      check("midrst_sp", 32'(sp), 32'h0);
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      step();
      rst = 1'b0; idle();
      step(); step();
`ifdef STORAGE_UNIT_STACK_GUARD_EN
      check("midrst_fault", 32'(fault), 32'h0);
`endif
      load = 1; ram_addr = 8'h10; expect_out(8'h77, 0, 8'h00); step(); idle();

      // Pop at empty
`ifdef STORAGE_UNIT_STACK_GUARD_EN
      pop = 1; step(); idle();
      check("unf_sp", 32'(sp), 32'h0);
      check("unf_fault", 32'(fault), 32'h1);
`else
      pop = 1; expect_out(8'hAF, 0, 8'h00); step(); idle();
      check("unf_sp", 32'(sp), 32'd15);
`endif

      step(); step(); step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule : tb_storage_unit
